// File: rtl/alu_operand_select.sv
// ALU operand-B selector: picks one of NUM_SRC packed sources per transaction
// and registers it behind a valid/ready handshake. A 2-entry skid buffer
// (main register M plus skid register S) sustains one transaction per cycle
// while in_ready stays a flop output.
// Optional feature macro: ALU_OPSEL_XFORM_EN adds the xform[1:0] port and
// applies a pass/sign-extend/zero-extend/shift-by-2 transform before capture.
module alu_operand_select #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SRC = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_bus,
`ifdef ALU_OPSEL_XFORM_EN
  input  logic [1:0]                xform,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                acc;
  logic                cmp;
  logic                load_m_in;
  logic                load_m_s;
  logic                load_s;
  logic [DATA_W-1:0]   sel_word;
  logic                sel_bad;
  logic [DATA_W-1:0]   cap_word;
  logic [DATA_W-1:0]   s_data;
  logic                s_err;

  // Source mux; an out-of-range index yields zero data and flags an error.
  always_comb begin
    sel_word = '0;
    sel_bad  = 1'b1;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_word = src_bus[k*DATA_W +: DATA_W];
        sel_bad  = 1'b0;
      end
    end
  end

`ifdef ALU_OPSEL_XFORM_EN
  // Operand transform; every transform of the zero word from a bad select is zero.
  always_comb begin
    cap_word = sel_word;
    case (xform)
      2'b01:   cap_word = {{(DATA_W-16){sel_word[15]}}, sel_word[15:0]};
      2'b10:   cap_word = {{(DATA_W-16){1'b0}}, sel_word[15:0]};
      2'b11:   cap_word = {sel_word[DATA_W-3:0], 2'b00};
      default: cap_word = sel_word;
    endcase
  end
`else
  // Without the transform the selected word is captured unmodified.
  always_comb begin
    cap_word = sel_word;
  end
`endif

  // Occupancy state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and storage load decode from accept/complete.
  always_comb begin
    state_d   = state_q;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    acc       = in_valid & in_ready;
    cmp       = out_valid & out_ready;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d   = ONE;
          load_m_in = 1'b1;
        end
      end
      ONE: begin
        if (acc && !cmp) begin
          state_d = TWO;
          load_s  = 1'b1;
        end else if (acc && cmp) begin
          load_m_in = 1'b1;
        end else if (cmp) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (cmp) begin
          state_d  = ONE;
          load_m_s = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake flags registered from next state so neither depends on out_ready combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d != TWO);
      out_valid <= (state_d != EMPTY);
    end
  end

  // Main and skid storage; M refills from input or from S, holding otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data <= '0;
      out_err  <= 1'b0;
      s_data   <= '0;
      s_err    <= 1'b0;
    end else begin
      if (load_m_in) begin
        out_data <= cap_word;
        out_err  <= sel_bad;
      end else if (load_m_s) begin
        out_data <= s_data;
        out_err  <= s_err;
      end
      if (load_s) begin
        s_data <= cap_word;
        s_err  <= sel_bad;
      end
    end
  end

endmodule
